// File: rtl/addsub_pipe.sv
// Pipelined two's-complement adder/subtractor, carry chain split into CHUNK-bit slices (one per stage).
// Latency: STAGES = WIDTH/CHUNK cycles from accept to out_valid when unstalled. Throughput is one beat per cycle.
// Backpressure: the whole pipe stalls when out_valid && !out_ready; in_ready = !out_valid || out_ready.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     operand handshake; a, b, sub sampled together on accept
//   out_valid/out_ready   result handshake; s, co, ofl, zero held while stalled
//   s                     result (a+b or a-b, mod 2^WIDTH)
//   co                    carry out of MSB (for sub: 1 = no borrow)
//   ofl                   signed overflow
//   zero                  s == 0, evaluated on the final (possibly clamped) s
// Build option: define ADDSUB_SAT_EN to clamp s to the signed extreme on overflow.
module addsub_pipe #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ofl,
    output logic             zero
);

    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;
    localparam int MSB    = WIDTH - 1;

`ifdef ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    // Pipeline registers; index k holds the state leaving stage k.
    // Every stage carries the full a/xb words: the not-yet-used high slices
    // form the skew path, and the MSBs feed the overflow check at the end.
    logic             r_v  [STAGES];
    logic [WIDTH-1:0] r_a  [STAGES];
    logic [WIDTH-1:0] r_xb [STAGES];
    logic [WIDTH-1:0] r_s  [STAGES];
    logic             r_c  [STAGES];
    logic             r_ofl;
    logic             r_zero;

    // Operands presented to stage k (stage 0 sees the input port).
    logic             op_v  [STAGES];
    logic [WIDTH-1:0] op_a  [STAGES];
    logic [WIDTH-1:0] op_xb [STAGES];
    logic [WIDTH-1:0] op_s  [STAGES];
    logic             op_c  [STAGES];

    logic [WIDTH-1:0] nx_s  [STAGES];
    logic             nx_c  [STAGES];
    logic [CHUNK:0]   slice_sum;
    logic [WIDTH-1:0] fin_s;
    logic             fin_ofl;
    logic             advance;

    assign out_valid = r_v[LAST];
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;

    assign s    = r_s[LAST];
    assign co   = r_c[LAST];
    assign ofl  = r_ofl;
    assign zero = r_zero;

    always_comb begin
        // Subtraction is a + ~b + 1: invert b here, inject the +1 as the stage-0 carry.
        op_v[0]  = in_valid;
        op_a[0]  = a;
        op_xb[0] = b ^ {WIDTH{sub}};
        op_s[0]  = '0;
        op_c[0]  = sub;
        for (int k = 1; k < STAGES; k++) begin
            op_v[k]  = r_v[k-1];
            op_a[k]  = r_a[k-1];
            op_xb[k] = r_xb[k-1];
            op_s[k]  = r_s[k-1];
            op_c[k]  = r_c[k-1];
        end

        slice_sum = '0;
        for (int k = 0; k < STAGES; k++) begin
            slice_sum = {1'b0, op_a[k][k*CHUNK +: CHUNK]}
                      + {1'b0, op_xb[k][k*CHUNK +: CHUNK]}
                      + {{CHUNK{1'b0}}, op_c[k]};
            // Lower slices already resolved pass through; only slice k is written.
            nx_s[k]                    = op_s[k];
            nx_s[k][k*CHUNK +: CHUNK]  = slice_sum[CHUNK-1:0];
            nx_c[k]                    = slice_sum[CHUNK];
        end

        // Overflow: operands share a sign and the result sign differs from it.
        fin_ofl = (op_a[LAST][MSB] == op_xb[LAST][MSB]) && (nx_s[LAST][MSB] != op_a[LAST][MSB]);
        fin_s   = nx_s[LAST];
`ifdef ADDSUB_SAT_EN
        // On overflow the true result has a's sign, so clamp toward that extreme.
        if (fin_ofl) begin
            fin_s = op_a[LAST][MSB] ? SMIN : SMAX;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_v[k]  <= 1'b0;
                r_a[k]  <= '0;
                r_xb[k] <= '0;
                r_s[k]  <= '0;
                r_c[k]  <= 1'b0;
            end
            r_ofl  <= 1'b0;
            r_zero <= 1'b0;
        end else if (advance) begin
            // Bubbles shift exactly like data; only the valid bit marks them.
            for (int k = 0; k < LAST; k++) begin
                r_v[k]  <= op_v[k];
                r_a[k]  <= op_a[k];
                r_xb[k] <= op_xb[k];
                r_s[k]  <= nx_s[k];
                r_c[k]  <= nx_c[k];
            end
            r_v[LAST]  <= op_v[LAST];
            r_a[LAST]  <= op_a[LAST];
            r_xb[LAST] <= op_xb[LAST];
            r_s[LAST]  <= fin_s;
            r_c[LAST]  <= nx_c[LAST];
            r_ofl      <= fin_ofl;
            r_zero     <= (fin_s == '0);
        end
    end

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe at WIDTH=16, CHUNK=4 (four stages).
// Directed table vectors, a random stream, a mid-stream stall and a mid-flight reset.
// Expected results come from the vector table or an integer reference model.
module tb_addsub_pipe;

    localparam int W  = 16;
    localparam int C  = 4;
    localparam int ST = W / C;
`ifdef ADDSUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] s;
    logic         co;
    logic         ofl;
    logic         zero;

    always #5 clk = ~clk;

    addsub_pipe #(.WIDTH(W), .CHUNK(C)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .co        (co),
        .ofl       (ofl),
        .zero      (zero)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        ofl;
        logic        zero;
    } vec_t;

    typedef struct {
        logic [15:0] s;
        logic        co;
        logic        ofl;
        logic        zero;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cnt   = 0;
    bit   chk_lat = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: plain integer arithmetic on the whole word.
    function automatic exp_t model(input logic [15:0] ia, input logic [15:0] ib, input logic isub);
        exp_t e;
        int   ua, ub, sa, sb, sr;
        ua = int'(ia);
        ub = int'(ib);
        sa = int'($signed(ia));
        sb = int'($signed(ib));
        if (isub) begin
            e.s  = 16'((ua - ub) & 32'hFFFF);
            e.co = (ua >= ub);
            sr   = sa - sb;
        end else begin
            e.s  = 16'((ua + ub) & 32'hFFFF);
            e.co = ((ua + ub) > 32'hFFFF);
            sr   = sa + sb;
        end
        e.ofl = (sr > 32767) || (sr < -32768);
        if (SAT && e.ofl) e.s = (sr > 0) ? 16'h7FFF : 16'h8000;
        e.zero = (e.s == 16'h0000);
        e.cyc  = 0;
        return e;
    endfunction

    // One clock: drive, look at the pre-edge state, score handshakes, step past the edge.
    task automatic cyc(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                       input logic isub, input logic ordy, input exp_t e,
                       output logic acc, output logic rdy, output logic [18:0] snap);
        exp_t f;
        in_valid  = iv;
        a         = ia;
        b         = ib;
        sub       = isub;
        out_ready = ordy;
        #1;
        rdy  = in_ready;
        acc  = iv && in_ready;
        snap = {s, co, ofl, zero};
        if (out_valid && ordy) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_out actual=%h required=none", snap);
            end else begin
                f = q.pop_front();
                check("result", 32'(snap), 32'({f.s, f.co, f.ofl, f.zero}));
                if (chk_lat) check("latency", 32'(cnt - f.cyc), 32'(ST));
            end
        end
        if (acc) begin
            f     = e;
            f.cyc = cnt;
            q.push_back(f);
        end
        @(posedge clk);
        #1;
        cnt++;
    endtask

    task automatic drain(input int bound);
        logic        ac, rd;
        logic [18:0] sn;
        exp_t        d;
        int          n;
        d = model(16'h0, 16'h0, 1'b0);
        n = 0;
        while (q.size() > 0 && n < bound) begin
            cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, d, ac, rd, sn);
            n++;
        end
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout left=%0d required=0", q.size());
            q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt[9];
        exp_t        e;
        logic        acc, rdy;
        logic [18:0] sn, hold;
        logic [15:0] pa, pb;
        logic        ps;
        int          sent, j;

        //              a         b         sub   s                              co    ofl   zero
        vt[0] = '{16'h7FFF, 16'h0001, 1'b0, SAT ? 16'h7FFF : 16'h8000,     1'b0, 1'b1, 1'b0};
        vt[1] = '{16'h0005, 16'h0005, 1'b1, 16'h0000,                      1'b1, 1'b0, 1'b1};
        vt[2] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF,                      1'b0, 1'b0, 1'b0};
        vt[3] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000,                      1'b1, 1'b0, 1'b1};
        vt[4] = '{16'h8000, 16'h0001, 1'b1, SAT ? 16'h8000 : 16'h7FFF,     1'b1, 1'b1, 1'b0};
        vt[5] = '{16'h1234, 16'h4321, 1'b0, 16'h5555,                      1'b0, 1'b0, 1'b0};
        vt[6] = '{16'h8000, 16'h8000, 1'b0, SAT ? 16'h8000 : 16'h0000,     1'b1, 1'b1, SAT ? 1'b0 : 1'b1};
        vt[7] = '{16'h0003, 16'h0007, 1'b1, 16'hFFFC,                      1'b0, 1'b0, 1'b0};
        vt[8] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000,                      1'b0, 1'b0, 1'b0};

        // Reset state, observed while rst_n is still low.
        #1 rst_n = 1'b0;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_outputs", 32'({s, co, ofl, zero}), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed vectors, one at a time through an empty pipe.
        for (int i = 0; i < 9; i++) begin
            e.s    = vt[i].s;
            e.co   = vt[i].co;
            e.ofl  = vt[i].ofl;
            e.zero = vt[i].zero;
            e.cyc  = 0;
            cyc(1'b1, vt[i].a, vt[i].b, vt[i].sub, 1'b1, e, acc, rdy, sn);
            check("vec_accept", 32'(acc), 32'd1);
            drain(ST + 4);
        end

        // Back-to-back random stream at full rate, mixed add/sub.
        for (int i = 0; i < 20; i++) begin
            pa = 16'($urandom);
            pb = 16'($urandom);
            ps = 1'($urandom_range(0, 1));
            cyc(1'b1, pa, pb, ps, 1'b1, model(pa, pb, ps), acc, rdy, sn);
            check("stream_accept", 32'(acc), 32'd1);
        end
        drain(ST + 4);

        // Three-cycle consumer stall in the middle of a stream.
        chk_lat = 1'b0;
        sent = 0;
        j    = 0;
        hold = '0;
        pa = 16'($urandom);
        pb = 16'($urandom);
        ps = 1'($urandom_range(0, 1));
        while (sent < 12 && j < 60) begin
            cyc(1'b1, pa, pb, ps, !(j >= 6 && j <= 8), model(pa, pb, ps), acc, rdy, sn);
            if (j >= 6 && j <= 8) check("stall_in_ready", 32'(rdy), 32'd0);
            if (j == 6) hold = sn;
            if (j == 7 || j == 8) check("stall_hold", 32'(sn), 32'(hold));
            if (acc) begin
                sent++;
                pa = 16'($urandom);
                pb = 16'($urandom);
                ps = 1'($urandom_range(0, 1));
            end
            j++;
        end
        check("stall_sent", 32'(sent), 32'd12);
        drain(ST + 8);

        // Fill the pipe behind a stalled consumer, then reset between edges.
        cyc(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, model(16'h7FFF, 16'h0001, 1'b0), acc, rdy, sn);
        cyc(1'b1, 16'h0001, 16'h0002, 1'b0, 1'b0, model(16'h0001, 16'h0002, 1'b0), acc, rdy, sn);
        cyc(1'b1, 16'h0009, 16'h0004, 1'b1, 1'b0, model(16'h0009, 16'h0004, 1'b1), acc, rdy, sn);
        cyc(1'b1, 16'hAAAA, 16'h1111, 1'b0, 1'b0, model(16'hAAAA, 16'h1111, 1'b0), acc, rdy, sn);
        check("pre_rst_out_valid", 32'(out_valid), 32'd1);
        check("pre_rst_ofl", 32'(ofl), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_outputs", 32'({s, co, ofl, zero}), 32'd0);
        rst_n = 1'b1;
        q.delete();
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk_lat = 1'b1;
        cyc(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b1, model(16'h1234, 16'h4321, 1'b0), acc, rdy, sn);
        check("post_rst_accept", 32'(acc), 32'd1);
        drain(ST + 4);
        // Idle a few more cycles: any old beat surfacing is reported as spurious.
        for (int i = 0; i < ST + 2; i++) begin
            cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, model(16'h0, 16'h0, 1'b0), acc, rdy, sn);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
